// File: rtl/palette_pkg.sv
// palette_pkg: shared definitions for the palette frame sequencer.
//   state_t      - sequencer FSM states
//   PIX_PER_WORD - 4-bit pixels packed into one 32-bit memory word
//   NIBBLE_W     - bits per palette index
//   RGB565_W     - decoded color width
package palette_pkg;

  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned NIBBLE_W     = 4;
  localparam int unsigned RGB565_W     = 16;
  localparam int unsigned WORD_W       = PIX_PER_WORD * NIBBLE_W;
  localparam int unsigned NIB_SEL_W    = $clog2(PIX_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: holds one fetched 32-bit word and steps through its
// eight 4-bit palette indices, leftmost (bits [3:0]) first.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_data, present nibble 0
//   i_advance      : present the next nibble
//   i_data         : packed pixel word
//   o_idx          : registered palette index of the current nibble
//   o_last         : current nibble is the final one of the word
module pixel_unpacker
  import palette_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic                i_advance,
  input  logic [WORD_W-1:0]   i_data,
  output logic [NIBBLE_W-1:0] o_idx,
  output logic                o_last
);

  logic [WORD_W-1:0]    r_buf;
  logic [NIB_SEL_W-1:0] r_nib;
  logic [NIBBLE_W-1:0]  r_idx;
  logic [NIB_SEL_W-1:0] w_nib_next;

  assign w_nib_next = r_nib + NIB_SEL_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
      r_nib <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
      r_nib <= '0;
      r_idx <= i_data[NIBBLE_W-1:0];
    end else if (i_advance) begin
      // Index register is loaded with the upcoming nibble so it is valid
      // in the same cycle the counter moves.
      r_nib <= w_nib_next;
      r_idx <= r_buf[w_nib_next * NIBBLE_W +: NIBBLE_W];
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_nib == NIB_SEL_W'(PIX_PER_WORD - 1));

endmodule

// File: rtl/palette_frame_sequencer.sv
// palette_frame_sequencer: fetches a frame of packed 4-bit palette indices
// from word-addressed memory, drives them to an external color decoder and
// forwards the decoded RGB565 color as a valid/ready pixel stream.
//   Clock, nReset        : clock, asynchronous active-low reset
//   Start / Busy / Done  : frame control handshake
//   MemRd, MemAddr       : one-cycle read request, address held until MemValid
//   MemValid, MemData    : read response strobe and packed pixels
//   ColorIdx / ColorIn   : registered decoder index / decoded color
//   PixData, PixValid, PixReady : pixel stream
//   PixFirst, PixLineEnd : markers for x=0,y=0 and x=H_RES-1
module palette_frame_sequencer
  import palette_pkg::*;
#(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Start,
  output logic                Busy,
  output logic                Done,
  output logic                MemRd,
  output logic [ADDR_W-1:0]   MemAddr,
  input  logic                MemValid,
  input  logic [WORD_W-1:0]   MemData,
  output logic [NIBBLE_W-1:0] ColorIdx,
  input  logic [RGB565_W-1:0] ColorIn,
  output logic [RGB565_W-1:0] PixData,
  output logic                PixValid,
  input  logic                PixReady,
  output logic                PixFirst,
  output logic                PixLineEnd
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(H_RES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(H_RES * V_RES / PIX_PER_WORD - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic                w_accept;
  logic                w_load;
  logic                w_last_nib;
  logic [NIBBLE_W-1:0] w_idx;

  pixel_unpacker u_unpacker (
    .i_clk     (Clock),
    .i_rst_n   (nReset),
    .i_load    (w_load),
    .i_advance (w_accept),
    .i_data    (MemData),
    .o_idx     (w_idx),
    .o_last    (w_last_nib)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    MemRd      = 1'b0;
    PixValid   = 1'b0;
    PixFirst   = 1'b0;
    PixLineEnd = 1'b0;
    case (r_state)
      ST_IDLE: if (Start) w_next = ST_REQ;
      ST_REQ: begin
        Busy   = 1'b1;
        MemRd  = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        Busy = 1'b1;
        if (MemValid) begin
          w_load = 1'b1;
          w_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        Busy       = 1'b1;
        PixValid   = 1'b1;
        PixFirst   = (r_x == '0) && (r_y == '0);
        PixLineEnd = (r_x == X_LAST);
        if (PixReady) begin
          w_accept = 1'b1;
          if (w_last_nib) w_next = (r_addr == LAST_WORD) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        Done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (r_state == ST_IDLE && Start) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_accept) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
      // Address stays on the last word when the frame ends.
      if (w_last_nib && r_addr != LAST_WORD) r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign MemAddr  = r_addr;
  assign ColorIdx = w_idx;
  assign PixData  = ColorIn;

endmodule
